// File: rtl/mem_wb_writeback.sv
// MEM/WB boundary: ALU results are written back 1 cycle after accept; loads take L+2 cycles.
// ex_mem_ready drops while a load is outstanding and rises again on the cycle the load data is written.
module mem_wb_writeback #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_valid,
    output logic              ex_mem_ready,
    input  logic              ex_mem_enrw,
    input  logic              ex_mem_mreg,
    input  logic [REG_AW-1:0] ex_mem_wn,
    input  logic [DATA_W-1:0] ex_mem_alu_res,
    output logic              mem_rd_req,
    output logic [DATA_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              M_WB_EnRW,
    output logic [REG_AW-1:0] M_WB_WN,
    output logic [DATA_W-1:0] M_WB_WD,
    output logic              load_pending,
    output logic [REG_AW-1:0] load_wn,
    output logic              mem_timeout
);

    localparam int CNT_W = 8;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic                wb_en_q, wb_en_d;
    logic [REG_AW-1:0]   wb_wn_q, wb_wn_d;
    logic [DATA_W-1:0]   wb_wd_q, wb_wd_d;
    logic                ld_en_q, ld_en_d;
    logic [REG_AW-1:0]   ld_wn_q, ld_wn_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic                tmo_q, tmo_d;
    logic                accept;
    logic                timeout_hit;

    assign accept      = ex_mem_valid & ex_mem_ready;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    // Read data on the final wait edge beats the timeout.
    assign timeout_hit = !mem_rd_valid && (cnt_inc == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && ex_mem_mreg)         state_d = S_WAIT;
            S_WAIT: if (mem_rd_valid || timeout_hit)   state_d = S_IDLE;
            default:                                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ex_mem_ready = (state_q == S_IDLE);
        mem_rd_req   = (state_q == S_WAIT);
        load_pending = (state_q == S_WAIT);
    end

    always_comb begin
        wb_en_d = 1'b0;
        wb_wn_d = wb_wn_q;
        wb_wd_d = wb_wd_q;
        ld_en_d = ld_en_q;
        ld_wn_d = ld_wn_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (ex_mem_mreg) begin
                        ld_en_d = ex_mem_enrw;
                        ld_wn_d = ex_mem_wn;
                        addr_d  = ex_mem_alu_res;
                        cnt_d   = '0;
                    end else begin
                        wb_en_d = ex_mem_enrw && (ex_mem_wn != '0);
                        wb_wn_d = ex_mem_wn;
                        wb_wd_d = ex_mem_alu_res;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rd_valid) begin
                    wb_en_d = ld_en_q && (ld_wn_q != '0);
                    wb_wn_d = ld_wn_q;
                    wb_wd_d = mem_rd_data;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            wb_en_q <= 1'b0;
            wb_wn_q <= '0;
            wb_wd_q <= '0;
            ld_en_q <= 1'b0;
            ld_wn_q <= '0;
            addr_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wb_en_q <= wb_en_d;
            wb_wn_q <= wb_wn_d;
            wb_wd_q <= wb_wd_d;
            ld_en_q <= ld_en_d;
            ld_wn_q <= ld_wn_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem_rd_addr = addr_q;
    assign M_WB_EnRW   = wb_en_q;
    assign M_WB_WN     = wb_wn_q;
    assign M_WB_WD     = wb_wd_q;
    assign load_wn     = ld_wn_q;
    assign mem_timeout = tmo_q;

endmodule
